// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard-control bundle: ID/EX operand info, EX/MA and MA/MO producer info,
// redirect/memory-wait inputs, and the stage-latch controls plus status returned by the controller.
`ifndef HBIT_SRC_GP
`define HBIT_SRC_GP 4
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 4
`endif

interface pipe_hazard_ctrl_if;
    logic [`HBIT_SRC_GP:0] iw_idex_src_gp;
    logic                  iw_idex_src_used;
    logic [`HBIT_TGT_GP:0] iw_idex_tgt_gp;
    logic                  iw_idex_tgt_used;
    logic [`HBIT_TGT_GP:0] iw_exma_tgt_gp;
    logic                  iw_exma_tgt_gp_we;
    logic                  iw_exma_is_load;
    logic [`HBIT_TGT_GP:0] iw_mamo_tgt_gp;
    logic                  iw_mamo_tgt_gp_we;
    logic                  iw_mamo_is_load;
    logic                  iw_redirect;
    logic                  iw_mem_busy;
    logic                  ow_freeze;
    logic                  ow_hold;
    logic                  ow_bubble;
    logic                  ow_flush;
    logic [1:0]            ow_state;
    logic [15:0]           ow_stall_cnt;
    logic [15:0]           ow_flush_cnt;
    logic                  ow_hazard_err;

    modport master (
        output iw_idex_src_gp, iw_idex_src_used, iw_idex_tgt_gp, iw_idex_tgt_used,
               iw_exma_tgt_gp, iw_exma_tgt_gp_we, iw_exma_is_load,
               iw_mamo_tgt_gp, iw_mamo_tgt_gp_we, iw_mamo_is_load,
               iw_redirect, iw_mem_busy,
        input  ow_freeze, ow_hold, ow_bubble, ow_flush, ow_state,
               ow_stall_cnt, ow_flush_cnt, ow_hazard_err
    );

    modport slave (
        input  iw_idex_src_gp, iw_idex_src_used, iw_idex_tgt_gp, iw_idex_tgt_used,
               iw_exma_tgt_gp, iw_exma_tgt_gp_we, iw_exma_is_load,
               iw_mamo_tgt_gp, iw_mamo_tgt_gp_we, iw_mamo_is_load,
               iw_redirect, iw_mem_busy,
        output ow_freeze, ow_hold, ow_bubble, ow_flush, ow_state,
               ow_stall_cnt, ow_flush_cnt, ow_hazard_err
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Execute-stage sequencing controller: load-use interlock, memory-wait freeze,
// multi-cycle front-end flush on redirect, saturating perf counters and a sticky interlock error.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MAX_HOLD     = 2
) (
    input logic             iw_clk,
    input logic             iw_rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FLUSH = 2'd1, ST_WAIT = 2'd2} state_e;

    localparam logic [2:0] FCNT_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] HOLD_LIMIT  = 3'(MAX_HOLD);

    state_e      state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic        pend_q, pend_d;
    logic [2:0]  hrun_q;
    logic        err_q;
    logic [15:0] stall_q, flcnt_q;

    logic exma_load, mamo_load, load_use, redir_eff;
    logic freeze_c, hold_c, flush_c;

    // Load data only reaches the operands from MO/WB, so a load still in EX/MA or MA/MO must interlock.
    assign exma_load = bus.iw_exma_tgt_gp_we & bus.iw_exma_is_load;
    assign mamo_load = bus.iw_mamo_tgt_gp_we & bus.iw_mamo_is_load;
    assign load_use =
        (bus.iw_idex_src_used & ((exma_load & (bus.iw_exma_tgt_gp == bus.iw_idex_src_gp)) |
                                 (mamo_load & (bus.iw_mamo_tgt_gp == bus.iw_idex_src_gp)))) |
        (bus.iw_idex_tgt_used & ((exma_load & (bus.iw_exma_tgt_gp == bus.iw_idex_tgt_gp)) |
                                 (mamo_load & (bus.iw_mamo_tgt_gp == bus.iw_idex_tgt_gp))));

    assign redir_eff = bus.iw_redirect | ((state_q == ST_WAIT) & pend_q);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state_q <= ST_RUN;
            fcnt_q  <= 3'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pend_q  <= pend_d;
        end
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pend_d  = pend_q;
        case (state_q)
            ST_RUN, ST_WAIT: begin
                if (bus.iw_mem_busy) begin
                    if (state_q == ST_RUN)    state_d = ST_WAIT;
                    else if (bus.iw_redirect) pend_d  = 1'b1;
                end else begin
                    pend_d  = 1'b0;
                    state_d = ST_RUN;
                    if (redir_eff) begin
                        fcnt_d  = FCNT_RELOAD;
                        state_d = (FCNT_RELOAD != 3'd0) ? ST_FLUSH : ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                if (!bus.iw_mem_busy) begin
                    // A redirect here restarts the sequence; this cycle is its first flush cycle.
                    fcnt_d  = bus.iw_redirect ? FCNT_RELOAD : fcnt_q - 3'd1;
                    state_d = (fcnt_d != 3'd0) ? ST_FLUSH : ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        freeze_c = bus.iw_mem_busy;
        hold_c   = 1'b0;
        flush_c  = 1'b0;
        if (!bus.iw_mem_busy) begin
            if (state_q == ST_FLUSH) flush_c = 1'b1;
            else if (redir_eff)      flush_c = 1'b1;
            else if (load_use)       hold_c  = 1'b1;
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            hrun_q  <= 3'd0;
            err_q   <= 1'b0;
            stall_q <= 16'd0;
            flcnt_q <= 16'd0;
        end else begin
            if (hold_c) begin
                if (hrun_q >= HOLD_LIMIT) err_q  <= 1'b1;
                if (hrun_q != 3'd7)       hrun_q <= hrun_q + 3'd1;
            end else begin
                hrun_q <= 3'd0;
            end
            if ((hold_c | freeze_c) && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (flush_c && flcnt_q != 16'hFFFF)             flcnt_q <= flcnt_q + 16'd1;
        end
    end

    // Combinational controls are forced low while reset is held.
    assign bus.ow_freeze     = iw_rst_n & freeze_c;
    assign bus.ow_hold       = iw_rst_n & hold_c;
    assign bus.ow_bubble     = iw_rst_n & hold_c;
    assign bus.ow_flush      = iw_rst_n & flush_c;
    assign bus.ow_state      = state_q;
    assign bus.ow_stall_cnt  = stall_q;
    assign bus.ow_flush_cnt  = flcnt_q;
    assign bus.ow_hazard_err = err_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the sequencing rules.
`ifndef HBIT_SRC_GP
`define HBIT_SRC_GP 4
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 4
`endif

module tb_pipe_hazard_ctrl;
    localparam int FC = 2;
    localparam int MH = 2;

    typedef logic [`HBIT_SRC_GP:0] src_t;
    typedef logic [`HBIT_TGT_GP:0] tgt_t;

    typedef struct {
        src_t src; bit su;
        tgt_t tgt; bit tu;
        tgt_t xt;  bit xw; bit xl;
        tgt_t mt;  bit mw; bit ml;
        bit   rd;  bit busy;
    } stim_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MAX_HOLD(MH)) dut (
        .iw_clk  (clk),
        .iw_rst_n(rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: mode 0 RUN / 1 FLUSH / 2 WAIT.
    int m_mode, m_left, m_hrun, m_stall, m_fl;
    bit m_pend, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.src = '0; s.su = 0; s.tgt = '0; s.tu = 0;
        s.xt = '0; s.xw = 0; s.xl = 0;
        s.mt = '0; s.mw = 0; s.ml = 0;
        s.rd = 0; s.busy = 0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.iw_idex_src_gp    = s.src;
        bus.iw_idex_src_used  = s.su;
        bus.iw_idex_tgt_gp    = s.tgt;
        bus.iw_idex_tgt_used  = s.tu;
        bus.iw_exma_tgt_gp    = s.xt;
        bus.iw_exma_tgt_gp_we = s.xw;
        bus.iw_exma_is_load   = s.xl;
        bus.iw_mamo_tgt_gp    = s.mt;
        bus.iw_mamo_tgt_gp_we = s.mw;
        bus.iw_mamo_is_load   = s.ml;
        bus.iw_redirect       = s.rd;
        bus.iw_mem_busy       = s.busy;
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_hrun = 0; m_stall = 0; m_fl = 0;
        m_pend = 0; m_err = 0;
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model, return at posedge+1.
    task automatic cycle(input stim_t s);
        bit lu, e_hold, e_fl;
        drive(s);
        @(negedge clk);
        lu = (s.su && ((s.xw && s.xl && s.xt == s.src) || (s.mw && s.ml && s.mt == s.src))) ||
             (s.tu && ((s.xw && s.xl && s.xt == s.tgt) || (s.mw && s.ml && s.mt == s.tgt)));
        e_hold = 0;
        e_fl   = 0;
        if (!s.busy) begin
            if (m_mode == 1 || s.rd || (m_mode == 2 && m_pend)) e_fl = 1;
            else if (lu) e_hold = 1;
        end
        check("freeze",    32'(bus.ow_freeze),     32'(s.busy));
        check("hold",      32'(bus.ow_hold),       32'(e_hold));
        check("bubble",    32'(bus.ow_bubble),     32'(e_hold));
        check("flush",     32'(bus.ow_flush),      32'(e_fl));
        check("state",     32'(bus.ow_state),      32'(m_mode));
        check("stall_cnt", 32'(bus.ow_stall_cnt),  32'(m_stall));
        check("flush_cnt", 32'(bus.ow_flush_cnt),  32'(m_fl));
        check("hz_err",    32'(bus.ow_hazard_err), 32'(m_err));

        if (s.busy) begin
            if (m_mode == 0) m_mode = 2;
            else if (m_mode == 2 && s.rd) m_pend = 1;
        end else if (m_mode == 1) begin
            m_left = s.rd ? FC - 1 : m_left - 1;
            m_mode = (m_left > 0) ? 1 : 0;
        end else begin
            m_pend = 0;
            if (e_fl) begin
                m_left = FC - 1;
                m_mode = (m_left > 0) ? 1 : 0;
            end else begin
                m_mode = 0;
            end
        end
        if (e_hold) begin
            if (m_hrun + 1 > MH) m_err = 1;
            m_hrun = (m_hrun < 7) ? m_hrun + 1 : 7;
        end else begin
            m_hrun = 0;
        end
        if ((e_hold || s.busy) && m_stall < 65535) m_stall++;
        if (e_fl && m_fl < 65535) m_fl++;
        @(posedge clk);
        #1;
    endtask

    // Assert reset with busy/redirect high so that zero outputs prove the gating.
    task automatic do_reset();
        stim_t s;
        s = idle();
        s.busy = 1; s.rd = 1;
        drive(s);
        rst_n = 1'b0;
        #1;
        check("rst_freeze", 32'(bus.ow_freeze),     32'd0);
        check("rst_hold",   32'(bus.ow_hold),       32'd0);
        check("rst_bubble", 32'(bus.ow_bubble),     32'd0);
        check("rst_flush",  32'(bus.ow_flush),      32'd0);
        check("rst_state",  32'(bus.ow_state),      32'd0);
        check("rst_stall",  32'(bus.ow_stall_cnt),  32'd0);
        check("rst_flcnt",  32'(bus.ow_flush_cnt),  32'd0);
        check("rst_err",    32'(bus.ow_hazard_err), 32'd0);
        model_reset();
        drive(idle());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_t s;
        drive(idle());
        #2;
        do_reset();

        // Load to r3 in EX/MA, consumer reads src r3: two holds as the load moves to MA/MO.
        s = idle(); s.xt = 3; s.xw = 1; s.xl = 1; s.src = 3; s.su = 1;
        cycle(s);
        s.xw = 0; s.xl = 0; s.mt = 3; s.mw = 1; s.ml = 1;
        cycle(s);
        cycle(idle());
        check("lu_stall_cnt", 32'(bus.ow_stall_cnt), 32'd2);
        check("lu_err",       32'(bus.ow_hazard_err), 32'd0);

        // ALU producer is forwardable: no hold on either operand.
        do_reset();
        s = idle(); s.xt = 3; s.xw = 1; s.src = 3; s.su = 1; s.tgt = 3; s.tu = 1;
        cycle(s);
        check("alu_stall_cnt", 32'(bus.ow_stall_cnt), 32'd0);

        // Redirect in RUN: two flush cycles, RUN -> FLUSH -> RUN.
        do_reset();
        s = idle(); s.rd = 1;
        cycle(s);
        check("rd_state_flush", 32'(bus.ow_state), 32'd1);
        cycle(idle());
        check("rd_state_run", 32'(bus.ow_state), 32'd0);
        cycle(idle());
        check("rd_flush_cnt", 32'(bus.ow_flush_cnt), 32'd2);

        // Redirect while waiting on memory: deferred until the freeze lifts.
        do_reset();
        s = idle(); s.busy = 1;
        cycle(s);
        check("wait_state", 32'(bus.ow_state), 32'd2);
        s.rd = 1;
        cycle(s);
        s.rd = 0;
        cycle(s);
        cycle(s);
        cycle(idle());
        cycle(idle());
        cycle(idle());
        check("wait_stall_cnt", 32'(bus.ow_stall_cnt), 32'd4);
        check("wait_flush_cnt", 32'(bus.ow_flush_cnt), 32'd2);

        // Load-use held three cycles exceeds MAX_HOLD; flag is sticky until reset.
        do_reset();
        s = idle(); s.xt = 5; s.xw = 1; s.xl = 1; s.tgt = 5; s.tu = 1;
        cycle(s);
        cycle(s);
        check("hz_err_pre", 32'(bus.ow_hazard_err), 32'd0);
        cycle(s);
        check("hz_err_set", 32'(bus.ow_hazard_err), 32'd1);
        cycle(idle());
        cycle(idle());
        check("hz_err_sticky", 32'(bus.ow_hazard_err), 32'd1);
        do_reset();
        check("hz_err_clr", 32'(bus.ow_hazard_err), 32'd0);

        // Reset in FLUSH with one flush cycle left aborts the sequence.
        s = idle(); s.rd = 1;
        cycle(s);
        check("abort_in_flush", 32'(bus.ow_state), 32'd1);
        do_reset();
        check("abort_state", 32'(bus.ow_state), 32'd0);
        check("abort_flush", 32'(bus.ow_flush), 32'd0);
        cycle(idle());

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            s.src  = src_t'($urandom_range(0, 3));
            s.tgt  = tgt_t'($urandom_range(0, 3));
            s.xt   = tgt_t'($urandom_range(0, 3));
            s.mt   = tgt_t'($urandom_range(0, 3));
            s.su   = 1'($urandom_range(0, 1));
            s.tu   = 1'($urandom_range(0, 1));
            s.xw   = 1'($urandom_range(0, 1));
            s.xl   = 1'($urandom_range(0, 1));
            s.mw   = 1'($urandom_range(0, 1));
            s.ml   = 1'($urandom_range(0, 1));
            s.busy = ($urandom_range(0, 4) == 0);
            s.rd   = ($urandom_range(0, 7) == 0);
            if (s.busy && m_mode == 1) s.rd = 0;
            cycle(s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
